// File: rtl/abus_arb_if.sv
// Bus interface for the four-master arbiter.
//   req   : level requests, bit 3 refresh (highest) .. bit 0 CPU (lowest)
//   done  : one-cycle end-of-transfer pulse from the current owner
//   ack   : one-hot grant
//   owner : encoded index of the granted master, 0 when the bus is free
//   busy  : high while any ack bit is high
// The master modport is the requester side; the slave modport is the arbiter.
interface abus_arb_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] ack;
  logic [1:0] owner;
  logic       busy;

  modport master (output req, output done, input ack, input owner, input busy);
  modport slave  (input req, input done, output ack, output owner, output busy);
endinterface

// File: rtl/abus_arb.sv
// Fixed-priority bus arbiter with hold timeout and one-shot fairness mask.
//   sys_clk : system clock, all state changes on the rising edge
//   resetl  : synchronous active-low reset
//   bus     : abus_arb_if.slave (req/done in, ack/owner/busy out)
// MAXHOLD (1..15) bounds how long one owner keeps the bus while another
// master is requesting.
//
// state | meaning
// IDLE  | bus free, arbitrate on any request
// OWN   | one master granted, hold counter running
// TURN  | one dead cycle after a transfer, then arbitrate as IDLE
module abus_arb #(
  parameter int unsigned MAXHOLD = 15
) (
  input  logic      sys_clk,
  input  logic      resetl,
  abus_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAXHOLD);

  state_t     state_q, state_d;
  logic [3:0] ack_q, ack_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] holdcnt_q, holdcnt_d;
  logic [3:0] pmask_q, pmask_d;

  logic [3:0] elig;
  logic [1:0] grant_idx;
  logic [3:0] grant_oh;
  logic [3:0] others;
  logic       timeout;

  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;
  assign bus.busy  = |ack_q;

  // The masked set falls back to the raw requests so a lone preempted
  // master is never locked out.
  always_comb begin
    elig = bus.req & ~pmask_q;
    if (elig == 4'b0000) elig = bus.req;
  end

  always_comb begin
    grant_idx = 2'd0;
    grant_oh  = 4'b0000;
    casez (elig)
      4'b1???: begin grant_idx = 2'd3; grant_oh = 4'b1000; end
      4'b01??: begin grant_idx = 2'd2; grant_oh = 4'b0100; end
      4'b001?: begin grant_idx = 2'd1; grant_oh = 4'b0010; end
      4'b0001: begin grant_idx = 2'd0; grant_oh = 4'b0001; end
      default: begin grant_idx = 2'd0; grant_oh = 4'b0000; end
    endcase
  end

  // Greater-or-equal so a competitor arriving after the counter has run
  // past the limit still forces a handover.
  assign others  = bus.req & ~ack_q;
  assign timeout = (holdcnt_q >= HOLD_LIM) && (others != 4'b0000);

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    owner_d   = owner_q;
    holdcnt_d = holdcnt_q;
    pmask_d   = pmask_q;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        holdcnt_d = 4'd0;
        if (bus.req != 4'b0000) begin
          state_d = ST_OWN;
          ack_d   = grant_oh;
          owner_d = grant_idx;
          pmask_d = 4'b0000;
        end else begin
          state_d = ST_IDLE;
          ack_d   = 4'b0000;
          owner_d = 2'd0;
        end
      end
      ST_OWN: begin
        if (bus.done || !bus.req[owner_q]) begin
          // done wins over a coincident timeout, so no mask is left behind
          state_d   = ST_TURN;
          ack_d     = 4'b0000;
          owner_d   = 2'd0;
          holdcnt_d = 4'd0;
          pmask_d   = 4'b0000;
        end else if (timeout) begin
          state_d   = ST_TURN;
          ack_d     = 4'b0000;
          owner_d   = 2'd0;
          holdcnt_d = 4'd0;
          pmask_d   = ack_q;
        end else if (holdcnt_q != 4'd15) begin
          holdcnt_d = holdcnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ack_d     = 4'b0000;
        owner_d   = 2'd0;
        holdcnt_d = 4'd0;
        pmask_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q   <= ST_IDLE;
      ack_q     <= 4'b0000;
      owner_q   <= 2'd0;
      holdcnt_q <= 4'd0;
      pmask_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      owner_q   <= owner_d;
      holdcnt_q <= holdcnt_d;
      pmask_q   <= pmask_d;
    end
  end

endmodule

// File: tb/tb_abus_arb.sv
module tb_abus_arb;

  logic       sys_clk;
  logic       resetl;
  logic [3:0] req_drv;
  logic       done_drv;
  logic       sel;          // 0 drives the MAXHOLD=3 arbiter, 1 the MAXHOLD=2 one
  int         n_tests;
  int         n_fail;

  abus_arb_if bus3 ();
  abus_arb_if bus2 ();

  assign bus3.req  = sel ? 4'b0000 : req_drv;
  assign bus3.done = sel ? 1'b0    : done_drv;
  assign bus2.req  = sel ? req_drv : 4'b0000;
  assign bus2.done = sel ? done_drv : 1'b0;

  abus_arb #(.MAXHOLD(3)) u_dut3 (.sys_clk(sys_clk), .resetl(resetl), .bus(bus3));
  abus_arb #(.MAXHOLD(2)) u_dut2 (.sys_clk(sys_clk), .resetl(resetl), .bus(bus2));

  logic [3:0] obs_ack;
  logic [1:0] obs_owner;
  logic       obs_busy;
  assign obs_ack   = sel ? bus2.ack   : bus3.ack;
  assign obs_owner = sel ? bus2.owner : bus3.owner;
  assign obs_busy  = sel ? bus2.busy  : bus3.busy;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_bus(input string tag, input logic [3:0] a, input logic [1:0] o);
    chk({tag, ".ack"},   {28'b0, obs_ack},   {28'b0, a});
    chk({tag, ".owner"}, {30'b0, obs_owner}, {30'b0, o});
    chk({tag, ".busy"},  {31'b0, obs_busy},  {31'b0, (a != 4'b0000)});
  endtask

  task automatic cyc();
    @(negedge sys_clk);
  endtask

  // Invariants on both arbiters every cycle
  always @(negedge sys_clk) begin
    chk("onehot3", {31'b0, $onehot0(bus3.ack)}, 32'd1);
    chk("busy3",   {31'b0, bus3.busy}, {31'b0, |bus3.ack});
    chk("onehot2", {31'b0, $onehot0(bus2.ack)}, 32'd1);
    chk("busy2",   {31'b0, bus2.busy}, {31'b0, |bus2.ack});
    if (!bus3.busy) chk("owner0_3", {30'b0, bus3.owner}, 32'd0);
    if (!bus2.busy) chk("owner0_2", {30'b0, bus2.owner}, 32'd0);
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    resetl   = 1'b0;
    req_drv  = 4'b0000;
    done_drv = 1'b0;
    sel      = 1'b0;

    // reset state, and no grant while reset is held with requests up
    cyc(); cyc();
    expect_bus("rst", 4'b0000, 2'd0);
    chk("rst.holdcnt", {28'b0, u_dut3.holdcnt_q}, 32'd0);
    chk("rst.pmask",   {28'b0, u_dut3.pmask_q},   32'd0);
    req_drv = 4'b1111;
    cyc(); expect_bus("rst_req", 4'b0000, 2'd0);
    req_drv = 4'b0000;
    resetl  = 1'b1;
    cyc(); expect_bus("idle", 4'b0000, 2'd0);

    // single request, done, drop
    req_drv = 4'b0001;
    cyc(); expect_bus("single.grant", 4'b0001, 2'd0);
    done_drv = 1'b1;
    cyc(); expect_bus("single.turn", 4'b0000, 2'd0);
    done_drv = 1'b0; req_drv = 4'b0000;
    cyc(); expect_bus("single.idle", 4'b0000, 2'd0);
    done_drv = 1'b1;
    cyc(); expect_bus("done_in_idle", 4'b0000, 2'd0);
    done_drv = 1'b0;

    // priority order and request changes ignored while owned
    req_drv = 4'b0111;
    cyc(); expect_bus("prio.obj", 4'b0100, 2'd2);
    done_drv = 1'b1; req_drv = 4'b0011;
    cyc(); expect_bus("prio.turn1", 4'b0000, 2'd0);
    done_drv = 1'b0;
    cyc(); expect_bus("prio.blit", 4'b0010, 2'd1);
    req_drv = 4'b1011;
    cyc(); expect_bus("prio.nopreempt", 4'b0010, 2'd1);
    req_drv = 4'b0011; done_drv = 1'b1; req_drv = 4'b0001;
    cyc(); expect_bus("prio.turn2", 4'b0000, 2'd0);
    done_drv = 1'b0;
    cyc(); expect_bus("prio.cpu", 4'b0001, 2'd0);
    done_drv = 1'b1; req_drv = 4'b0000;
    cyc(); expect_bus("prio.turn3", 4'b0000, 2'd0);
    done_drv = 1'b0;
    cyc(); expect_bus("prio.idle", 4'b0000, 2'd0);

    // timeout with MAXHOLD=3: CPU holds 4 cycles, refresh takes over
    req_drv = 4'b0001;
    cyc(); expect_bus("to.cpu0", 4'b0001, 2'd0);
    req_drv = 4'b1001;
    for (int i = 1; i <= 3; i++) begin
      cyc(); expect_bus("to.cpu", 4'b0001, 2'd0);
    end
    cyc(); expect_bus("to.turn", 4'b0000, 2'd0);
    chk("to.pmask", {28'b0, u_dut3.pmask_q}, 32'h1);
    cyc(); expect_bus("to.refresh", 4'b1000, 2'd3);
    chk("to.pmask_clr", {28'b0, u_dut3.pmask_q}, 32'h0);
    done_drv = 1'b1; req_drv = 4'b0000;
    cyc(); expect_bus("to.turn2", 4'b0000, 2'd0);
    done_drv = 1'b0;
    cyc(); expect_bus("to.idle", 4'b0000, 2'd0);

    // timeout, competitor gone in TURN: masked CPU regranted
    req_drv = 4'b0001;
    cyc(); expect_bus("byp.cpu0", 4'b0001, 2'd0);
    req_drv = 4'b1001;
    for (int i = 1; i <= 3; i++) begin
      cyc(); expect_bus("byp.cpu", 4'b0001, 2'd0);
    end
    cyc(); expect_bus("byp.turn", 4'b0000, 2'd0);
    req_drv = 4'b0001;
    cyc(); expect_bus("byp.regrant", 4'b0001, 2'd0);
    chk("byp.pmask", {28'b0, u_dut3.pmask_q}, 32'h0);
    req_drv = 4'b0000;
    cyc(); expect_bus("byp.turn2", 4'b0000, 2'd0);
    cyc(); expect_bus("byp.idle", 4'b0000, 2'd0);

    // MAXHOLD=2 arbiter: alternating fairness between blitter and CPU
    sel = 1'b1;
    req_drv = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_bus("fair.blit", 4'b0010, 2'd1);
    end
    cyc(); expect_bus("fair.turn1", 4'b0000, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_bus("fair.cpu", 4'b0001, 2'd0);
    end
    cyc(); expect_bus("fair.turn2", 4'b0000, 2'd0);
    cyc(); expect_bus("fair.blit2", 4'b0010, 2'd1);
    req_drv = 4'b0000;
    cyc(); expect_bus("fair.turn3", 4'b0000, 2'd0);
    cyc(); expect_bus("fair.idle", 4'b0000, 2'd0);

    // done coinciding with timeout: no mask, blitter regranted
    req_drv = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_bus("dto.blit", 4'b0010, 2'd1);
    end
    done_drv = 1'b1;
    cyc(); expect_bus("dto.turn", 4'b0000, 2'd0);
    done_drv = 1'b0;
    cyc(); expect_bus("dto.blit2", 4'b0010, 2'd1);
    req_drv = 4'b0000;
    cyc(); expect_bus("dto.turn2", 4'b0000, 2'd0);
    cyc(); expect_bus("dto.idle", 4'b0000, 2'd0);

    // sole requester keeps the bus well past MAXHOLD
    req_drv = 4'b0001;
    for (int i = 0; i < 25; i++) begin
      cyc(); expect_bus("sole.cpu", 4'b0001, 2'd0);
    end
    req_drv = 4'b0000;
    cyc(); expect_bus("sole.turn", 4'b0000, 2'd0);
    cyc(); expect_bus("sole.idle", 4'b0000, 2'd0);

    // reset in the middle of a transfer
    sel = 1'b0;
    req_drv = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_bus("mrst.ref", 4'b1000, 2'd3);
    end
    resetl = 1'b0;
    cyc(); expect_bus("mrst.reset", 4'b0000, 2'd0);
    chk("mrst.holdcnt", {28'b0, u_dut3.holdcnt_q}, 32'd0);
    resetl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_bus("mrst.ref2", 4'b1000, 2'd3);
    end
    cyc(); expect_bus("mrst.turn", 4'b0000, 2'd0);
    cyc(); expect_bus("mrst.obj", 4'b0100, 2'd2);
    req_drv = 4'b0000;
    cyc(); expect_bus("mrst.turn2", 4'b0000, 2'd0);
    cyc(); expect_bus("mrst.idle", 4'b0000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/abus_arb.md
ABUS_ARB -- requirements
Module: abus_arb

Interface
REQ-001 Parameter: MAXHOLD, default 15, max cycles one master may keep the bus while another master is requesting; legal range 1..15.
REQ-002 Port: sys_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: resetl  input  1  reset, synchronous and active-low, sampled on the sys_clk rising edge.
REQ-004 Port: req  input  4  bus requests, level; bit 3 refresh (highest priority), bit 2 object processor, bit 1 blitter, bit 0 CPU (lowest).
REQ-005 Port: done  input  1  one-cycle pulse from the current owner marking the end of its transfer; ignored when no grant is active.
REQ-006 Port: ack  output  4  one-hot grant; at most one bit set in any cycle.
REQ-007 Port: owner  output  2  encoded index of the granted master; valid only while busy=1, 0 otherwise.
REQ-008 Port: busy  output  1  high exactly when any ack bit is high.

Function
REQ-009 States: IDLE, OWN, TURN; 4-bit hold counter holdcnt; 4-bit one-shot mask pmask.
REQ-010 IDLE: ack=0; if any req bit is high, next state is OWN, granting the highest-priority eligible requester.
REQ-011 Eligible requesters are req & ~pmask; if that set is empty, they are req.
REQ-012 Grant latency: ack asserts on the clock edge that samples req high in IDLE or TURN (one cycle from request to grant).
REQ-013 OWN: ack and owner hold constant; holdcnt increments by 1 per cycle and saturates at 15.
REQ-014 OWN exits to TURN on the first of: done=1; req[owner]=0; holdcnt==MAXHOLD while any other req bit is high.
REQ-015 No exit from OWN on timeout when no other master requests; the owner keeps the bus indefinitely.
REQ-016 Higher-priority requests never preempt an owner except through the timeout in REQ-014.
REQ-017 Timeout exit: pmask is set to the preempted owner's one-hot bit.
REQ-018 Exit by done or request drop: pmask is cleared.
REQ-019 pmask is also cleared after any grant that follows it.
REQ-020 done and timeout in the same cycle count as done; pmask is cleared.
REQ-021 TURN lasts exactly one cycle with ack=0 (bus turnaround).
REQ-022 TURN clears holdcnt, then arbitrates exactly as IDLE.
REQ-023 Back-to-back transfers therefore cost one dead cycle; the same master may be regranted after TURN when it is still highest eligible.
REQ-024 done received in IDLE or TURN has no effect.
REQ-025 Request bits changing while another master owns the bus have no effect on ack.

Reset
REQ-026 resetl=0 at a rising edge forces the following in the same edge, regardless of state or in-flight transfer: state IDLE, ack=0, owner=0, busy=0, holdcnt=0, pmask=0.
REQ-027 While resetl=0, no grant is issued even with req high.
REQ-028 The first arbitration occurs at the first edge with resetl=1.

Verification
REQ-029 Single request: req=0001 from IDLE -> ack=0001 and busy=1 next cycle; done pulse -> ack=0 next cycle (TURN); req dropped -> IDLE.
REQ-030 Priority: req=0111 simultaneously in IDLE -> ack=0100, owner=2; after done -> one TURN cycle, then ack=0010.
REQ-031 Timeout, MAXHOLD=3: CPU granted; req[3] asserted while CPU holds -> CPU keeps ack for exactly 4 cycles (holdcnt 0..3); TURN; ack=1000.
REQ-032 Timeout with sole requester (pmask bypass): same as REQ-031 but req[3] drops during TURN -> CPU regranted despite pmask; pmask=0 afterwards.
REQ-033 Timeout fairness: req=0011 held, MAXHOLD=2 -> blitter preempted, CPU granted next; no-other-request case (MAXHOLD=2, only CPU requesting) -> CPU holds >20 cycles without TURN.
REQ-034 Reset mid-transfer: resetl=0 during OWN with req=1111 -> ack=0 and busy=0 at that edge; resetl=1 -> ack=1000 one cycle later.
REQ-035 All scenarios check continuously: ack one-hot or zero; busy equals OR of ack.
